// File: rtl/s_mem_arbiter_if.sv
// Requester-side bus of the s_memory arbiter: per-requester request/lock/address/data
// plus the grant, broadcast read data and per-requester read-valid strobes.
interface s_mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
) ();
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      lock;
    logic [NUM_REQ-1:0][7:0] addr;
    logic [NUM_REQ-1:0][7:0] wdata;
    logic [NUM_REQ-1:0]      wren;
    logic [NUM_REQ-1:0]      gnt;
    logic [7:0]              rdata;
    logic [NUM_REQ-1:0]      rvalid;

    modport master (
        output req, lock, addr, wdata, wren,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, lock, addr, wdata, wren,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/s_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous s_memory port among NUM_REQ requesters,
// with optional hold limit (forced release under contention) and per-requester lock.
module s_mem_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned HOLD_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    s_mem_arbiter_if.slave        bus,
    output logic [7:0]            mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_wren,
    input  logic [7:0]            mem_q,
    output logic                  busy,
    output logic [1:0]            owner_id
);

    localparam int unsigned HoldW = (HOLD_LIMIT < 2) ? 1 : $clog2(HOLD_LIMIT + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_LIMIT);
    localparam logic [HoldW-1:0] HoldOne = HoldW'(1);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] rvalid_q;

    logic [NUM_REQ-1:0] owner_oh;
    logic               owner_req, owner_lock, owner_wren, others_req;
    logic [HoldW-1:0]   hold_inc;
    logic               limit_hit;
    logic [1:0]         winner, rr_next;
    logic               found;
    int unsigned        cand;
    logic               mem_active;

    always_comb begin
        owner_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == 2'(i));
        end
    end

    assign owner_req  = |(bus.req & owner_oh);
    assign owner_lock = |(bus.lock & owner_oh);
    assign owner_wren = |(bus.wren & owner_oh);
    assign others_req = |(bus.req & ~owner_oh);

    // hold_inc counts the granted cycle now ending, so a limit of N releases after N cycles
    assign hold_inc  = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + HoldOne;
    assign limit_hit = (HOLD_LIMIT != 0) && (hold_inc == HoldMax);

    // Round-robin search starting at rr_ptr_q, wrapping at NUM_REQ-1
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = 2'(cand);
            end
        end
    end

    assign rr_next = (32'(winner) == NUM_REQ - 1) ? 2'd0 : winner + 2'd1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d    = StOwned;
                    owner_d    = winner;
                    rr_ptr_d   = rr_next;
                    hold_cnt_d = '0;
                end
            end
            StOwned: begin
                if (!owner_req) begin
                    state_d = StIdle;
                    owner_d = 2'd0;
                end else if (limit_hit && !owner_lock && others_req) begin
                    state_d = StIdle;
                    owner_d = 2'd0;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= 2'd0;
            rr_ptr_q   <= 2'd0;
            hold_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid_q   <= bus.gnt & bus.req & ~bus.wren;
        end
    end

    // Reset gates the memory port in the same cycle so a burst in flight stops writing
    assign mem_active = !reset && (state_q == StOwned) && owner_req;

    always_comb begin
        mem_addr = 8'h00;
        mem_data = 8'h00;
        mem_wren = 1'b0;
        if (mem_active) begin
            mem_wren = owner_wren;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (owner_oh[i]) begin
                    mem_addr = bus.addr[i];
                    mem_data = bus.wdata[i];
                end
            end
        end
    end

    assign bus.gnt    = (state_q == StOwned) ? owner_oh : '0;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = mem_q;
    assign busy       = (state_q == StOwned);
    assign owner_id   = (state_q == StOwned) ? owner_q : 2'd0;

endmodule

// File: doc/s_mem_arbiter.md
S_MEM_ARBITER -- requirements
Module: s_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing s_memory (2..4).
REQ-002 Parameter HOLD_LIMIT, default 16: granted cycles before forced release when contended; 0 = unlimited.
REQ-003 clk  in  1  system clock (CLK_50M at top level); all logic rises on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req  in  NUM_REQ  per-requester access request, level, held for the whole burst.
REQ-006 lock  in  NUM_REQ  per-requester lock; blocks forced release (swap read-modify-write).
REQ-007 addr  in  NUM_REQ x 8  per-requester s_memory address.
REQ-008 wdata  in  NUM_REQ x 8  per-requester write data.
REQ-009 wren  in  NUM_REQ  per-requester write enable.
REQ-010 gnt  out  NUM_REQ  one-hot grant, registered.
REQ-011 rdata  out  8  read data, mem_q broadcast to all requesters.
REQ-012 rvalid  out  NUM_REQ  per-requester read-data-valid strobe, registered.
REQ-013 mem_addr  out  8  to s_memory address.
REQ-014 mem_data  out  8  to s_memory data.
REQ-015 mem_wren  out  1  to s_memory wren.
REQ-016 mem_q  in  8  from s_memory q; valid 1 cycle after address presented.
REQ-017 busy  out  1  high while any grant held.
REQ-018 owner_id  out  2  index of current owner; 0 when idle.

Function
REQ-019 FSM states IDLE and OWNED only; reset enters IDLE.
REQ-020 IDLE: if any req high at posedge, select winner, go OWNED, gnt[winner]=1 from next cycle (1-cycle req-to-gnt latency); else stay IDLE.
REQ-021 Round-robin: search starts at rr_ptr, wraps NUM_REQ-1 -> 0; on grant, rr_ptr <= winner+1 modulo NUM_REQ.
REQ-022 OWNED: mem_addr/mem_data driven combinationally from owner's addr/wdata; mem_wren = wren[owner] & req[owner].
REQ-023 Not OWNED, or owner req low: mem_wren=0, mem_addr=0, mem_data=0.
REQ-024 Voluntary release: owner req low at posedge -> IDLE, gnt low next cycle; re-arbitration no earlier than the following posedge (one dead cycle between owners).
REQ-025 hold_cnt: cleared on grant, +1 per OWNED cycle, saturates at HOLD_LIMIT.
REQ-026 Forced release: HOLD_LIMIT!=0, hold_cnt==HOLD_LIMIT, lock[owner]=0, another req high -> IDLE as REQ-024; owner re-arbitrates normally.
REQ-027 lock[owner]=1 suppresses forced release indefinitely; lock on non-owner has no effect.
REQ-028 rvalid[i] <= gnt[i] & req[i] & ~wren[i]; one-cycle pulse aligned with mem_q; a read in the owner's last granted cycle still produces rvalid next cycle.
REQ-029 Write then read same address in consecutive owner cycles returns new data (s_memory read-after-write); arbiter adds no bypass.
REQ-030 gnt always one-hot or zero; busy = |gnt; owner_id = index of set gnt bit.
REQ-031 req from a non-owner while OWNED is queued only by remaining high; no request memory inside arbiter.

Reset
REQ-032 reset high at posedge: state IDLE, gnt=0, rvalid=0, rr_ptr=0, hold_cnt=0, busy=0, owner_id=0; mem_wren=0 same cycle combinationally.
REQ-033 Reset mid-burst aborts ownership with no further writes; requesters must re-request after reset drops.
REQ-034 reset overrides every other input including lock.

Verification
REQ-035 req=3'b111 after reset -> gnt=001 one cycle later; drop req[0] -> gnt=000 one cycle, then gnt=010; later gnt=100 (round-robin).
REQ-036 Owner 0 writes addr 8'h05 data 8'hA5, next cycle reads 8'h05 -> rvalid[0] pulses one cycle with rdata=8'hA5; other rvalid bits stay 0.
REQ-037 HOLD_LIMIT=4, req[0] held, req[1] raised at grant -> gnt[0] drops after exactly 4 granted cycles, gnt[1] rises 2 cycles later.
REQ-038 Same as REQ-037 with lock[0]=1 -> gnt[0] held 20 cycles with no release; release only after lock[0] and req[0] drop.
REQ-039 reset asserted during owner-2 write burst -> mem_wren=0 same cycle, gnt=000 next cycle, memory location after reset-cycle address unchanged.
REQ-040 Sole requester with HOLD_LIMIT=4 held 50 cycles -> no forced release (no contender), gnt continuous.
